// File: rtl/mul_sequencer.sv
// mul_sequencer: drives an external iterative multiplier through load, step and capture phases, with MFHI/MFLO readback.
// With MUL_SEQ_EARLY_EXIT_EN defined, RUN stops once no set bits of b remain.
module mul_sequencer #(
  parameter int          MUL_CYCLES = 32,
  parameter logic [5:0]  MULTU_CODE = 6'b011001,
  parameter logic [5:0]  OUT_CODE   = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [5:0]  mul_signal,
  output logic [31:0] mul_dataA,
  output logic [31:0] mul_dataB,
  input  logic [63:0] mul_product,
  output logic        busy,
  output logic        done,
  output logic        result_valid,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] result
);
  localparam int CW = $clog2(MUL_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic load_skip, run_last;
  wire is_read = start && (funct == 6'b010000 || funct == 6'b010010);
`ifdef MUL_SEQ_EARLY_EXIT_EN
  logic [31:0] b_sh;
  assign load_skip = mul_dataB == '0;
  assign run_last  = cnt == '0 || b_sh[31:1] == '0;
  always_ff @(posedge clk)
    if (reset) b_sh <= '0;
    else b_sh <= state == LOAD ? mul_dataB : state == RUN ? b_sh >> 1 : b_sh;
`else
  assign load_skip = 1'b0;
  assign run_last  = cnt == '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      mul_signal   <= '0;
      mul_dataA    <= '0;
      mul_dataB    <= '0;
      hi           <= '0;
      lo           <= '0;
      result       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      done         <= 1'b0;
      result_valid <= is_read;
      if (is_read) result <= funct[1] ? lo : hi;
      case (state)
        IDLE: if (start && funct == MULTU_CODE) begin
          mul_dataA  <= a_in;
          mul_dataB  <= b_in;
          mul_signal <= OUT_CODE;
          busy       <= 1'b1;
          state      <= LOAD;
        end
        LOAD: begin
          cnt        <= CW'(MUL_CYCLES - 1);
          mul_signal <= load_skip ? 6'b000000 : MULTU_CODE;
          state      <= load_skip ? CAPTURE : RUN;
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (run_last) begin
            mul_signal <= '0;
            state      <= CAPTURE;
          end
        end
        default: begin
          hi    <= mul_product[63:32];
          lo    <= mul_product[31:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed self-checking bench; the multiplier stage is a behavioural full product of the held operands.
module tb_mul_sequencer;
  logic        clk = 0, reset = 1, start = 0;
  logic [5:0]  funct = 0;
  logic [31:0] a_in = 0, b_in = 0;
  logic [5:0]  mul_signal;
  logic [31:0] mul_dataA, mul_dataB, hi, lo, result;
  logic [63:0] mul_product;
  logic        busy, done, result_valid;
  int n_cmp = 0, n_err = 0;
  localparam logic [5:0] MULTU = 6'b011001, OUTC = 6'b111111, MFHI = 6'b010000, MFLO = 6'b010010;

  mul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .a_in(a_in), .b_in(b_in),
    .mul_signal(mul_signal), .mul_dataA(mul_dataA), .mul_dataB(mul_dataB),
    .mul_product(mul_product), .busy(busy), .done(done), .result_valid(result_valid),
    .hi(hi), .lo(lo), .result(result)
  );

  assign mul_product = {32'b0, mul_dataA} * {32'b0, mul_dataB};
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cycle (counted from the acceptance edge) in which done rises
  function automatic int exp_cycles(input logic [31:0] b);
    int l = 0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
    for (int i = 0; i < 32; i++) if (b[i]) l = i + 1;
    return 3 + l;
`else
    l = b == 0 ? 0 : 0;
    return 35 + l;
`endif
  endfunction

  task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    start = 1; funct = MULTU; a_in = a; b_in = b;
    tick;
    start = 0;
    n = 1;
    while (!done && n < 100) begin tick; n++; end
    chk({tag, "_cycle"}, n, exp_cycles(b));
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    chk({tag, "_model"}, {hi, lo}, p);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic read(input string tag, input logic [5:0] f, input logic [31:0] exp);
    start = 1; funct = f;
    tick;
    start = 0;
    chk({tag, "_data"}, result, exp);
    chk({tag, "_valid"}, result_valid, 1);
    tick;
    chk({tag, "_valid_drop"}, result_valid, 0);
  endtask

  initial begin
    int n, dones, run;
    tick; tick;
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", mul_signal, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_dataA", mul_dataA, 0);

    // 3x5 with per-cycle command checks
    start = 1; funct = MULTU; a_in = 3; b_in = 5;
    tick;
    start = 0;
    chk("c1_sig", mul_signal, OUTC);
    chk("c1_busy", busy, 1);
    chk("c1_dataA", mul_dataA, 3);
    chk("c1_dataB", mul_dataB, 5);
    run = exp_cycles(5) - 3;
    for (int i = 0; i < run; i++) begin tick; chk("run_sig", mul_signal, MULTU); end
    tick;
    chk("cap_sig", mul_signal, 0);
    chk("cap_busy", busy, 1);
    chk("cap_done", done, 0);
    tick;
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_hi", hi, 0);
    chk("fin_lo", lo, 15);
    tick;
    chk("fin_done_drop", done, 0);

    mul_op("ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    read("mfhi", MFHI, 32'hFFFFFFFE);
    read("mflo", MFLO, 32'h00000001);

    start = 1; funct = 6'b000001;
    tick;
    start = 0;
    chk("nop_busy", busy, 0);
    chk("nop_rv", result_valid, 0);

    // second start in cycle 10 must be ignored
    start = 1; funct = MULTU; a_in = 6; b_in = 32'h80000004;
    tick;
    start = 0;
    for (int i = 1; i < 10; i++) tick;
    start = 1; a_in = 7; b_in = 9;
    tick;
    start = 0;
    chk("ign_dataA", mul_dataA, 6);
    chk("ign_dataB", mul_dataB, 32'h80000004);
    chk("ign_busy", busy, 1);
    n = 11;
    while (!done && n < 100) begin tick; n++; end
    chk("ign_cycle", n, 35);
    chk("ign_hi", hi, 3);
    chk("ign_lo", lo, 32'h18);
    dones = 0;
    for (int i = 0; i < 40; i++) begin tick; if (done) dones++; end
    chk("ign_no_done", dones, 0);

    // reset in RUN cycle 20 aborts
    start = 1; funct = MULTU; a_in = 8; b_in = 32'h80000000;
    tick;
    start = 0;
    for (int i = 1; i < 20; i++) tick;
    chk("abort_in_run", mul_signal, MULTU);
    reset = 1;
    tick;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_done", done, 0);
    chk("abort_sig", mul_signal, 0);
    start = 1; funct = MULTU; a_in = 9; b_in = 9;
    tick;
    chk("rst_prio_busy", busy, 0);
    start = 0; reset = 0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin tick; if (done) dones++; end
    chk("abort_no_done", dones, 0);
    mul_op("two", 2, 2, 0, 4);

    mul_op("b1", 9, 1, 0, 9);
    mul_op("b0", 5, 0, 0, 0);
    read("mflo_b0", MFLO, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
